// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage and the data-memory load/store front end.
interface data_mem_ctrl_if;
    logic        i_valid;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_err;

    modport master (
        output i_valid, i_we, i_size, i_unsigned, i_addr, i_wdata,
        input  o_ready, o_rvalid, o_rdata, o_err
    );

    modport slave (
        input  i_valid, i_we, i_size, i_unsigned, i_addr, i_wdata,
        output o_ready, o_rvalid, o_rdata, o_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store front end for the MIPS data memory: lane alignment, range/misalignment
// rejection and load extension around a byte-enable BRAM with a one-cycle registered read.
module data_mem_ctrl #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int RAM_DEPTH = 512,
    localparam int AW = $clog2(RAM_DEPTH),
    localparam int DW = NB_COL * COL_WIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    data_mem_ctrl_if.slave    bus,
    output logic [AW-1:0]     o_ram_waddr,
    output logic [AW-1:0]     o_ram_raddr,
    output logic [DW-1:0]     o_ram_din,
    output logic [NB_COL-1:0] o_ram_wen,
    output logic              o_ram_ren,
    input  logic [DW-1:0]     i_ram_dout
);

    localparam logic [31:0] DEPTH_U = 32'(RAM_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT} state_t;

    function automatic logic [NB_COL-1:0] lane_wen(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_wen = 4'b0001 << off;
            2'b01:   lane_wen = off[1] ? 4'b1100 : 4'b0011;
            default: lane_wen = 4'b1111;
        endcase
    endfunction

    function automatic logic [DW-1:0] lane_din(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   lane_din = {4{wdata[7:0]}};
            2'b01:   lane_din = {2{wdata[15:0]}};
            default: lane_din = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] off,
                                                input logic uns, input logic [DW-1:0] dout);
        logic [7:0]  b;
        logic [15:0] h;
        b = dout[{off, 3'b000} +: 8];
        h = off[1] ? dout[31:16] : dout[15:0];
        case (size)
            2'b00:   load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_extend = dout;
        endcase
    endfunction

    state_t              state;
    logic                we_p1;
    logic [1:0]          size_p1;
    logic [1:0]          off_p1;
    logic                uns_p1;
    logic [AW-1:0]       waddr_p1;
    logic [DW-1:0]       din_p1;
    logic [NB_COL-1:0]   wen_p1;
    logic                ren_p1;
    logic                err_p1;
    logic                rvalid_p2;
    logic [31:0]         rdata_p2;
    logic                req_err;

    assign req_err = (bus.i_size == 2'b11)
                   | ((bus.i_size == 2'b01) & bus.i_addr[0])
                   | ((bus.i_size == 2'b10) & (|bus.i_addr[1:0]))
                   | ({2'b00, bus.i_addr[31:2]} >= DEPTH_U);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            wen_p1    <= '0;
            ren_p1    <= 1'b0;
            waddr_p1  <= '0;
            din_p1    <= '0;
            err_p1    <= 1'b0;
            rvalid_p2 <= 1'b0;
            rdata_p2  <= '0;
        end else begin
            wen_p1    <= '0;
            ren_p1    <= 1'b0;
            waddr_p1  <= '0;
            din_p1    <= '0;
            err_p1    <= 1'b0;
            rvalid_p2 <= 1'b0;
            unique case (state)
                // p0 -> p1: accept, check and register the request with its BRAM drive
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        if (req_err) begin
                            err_p1 <= 1'b1;
                        end else begin
                            we_p1    <= bus.i_we;
                            size_p1  <= bus.i_size;
                            off_p1   <= bus.i_addr[1:0];
                            uns_p1   <= bus.i_unsigned;
                            waddr_p1 <= bus.i_addr[AW+1:2];
                            if (bus.i_we) begin
                                wen_p1 <= lane_wen(bus.i_size, bus.i_addr[1:0]);
                                din_p1 <= lane_din(bus.i_size, bus.i_wdata);
                            end else begin
                                ren_p1 <= 1'b1;
                            end
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: state <= we_p1 ? ST_IDLE : ST_WAIT;
                // p1 -> p2: BRAM data is valid, extract and extend the load result
                ST_WAIT: begin
                    rdata_p2  <= load_extend(size_p1, off_p1, uns_p1, i_ram_dout);
                    rvalid_p2 <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A store sitting in ACCESS while reset is asserted must not reach the array.
    assign o_ram_wen   = i_rst ? '0 : wen_p1;
    assign o_ram_ren   = ren_p1;
    assign o_ram_waddr = waddr_p1;
    assign o_ram_raddr = waddr_p1;
    assign o_ram_din   = din_p1;

    assign bus.o_ready  = (state == ST_IDLE);
    assign bus.o_rvalid = rvalid_p2;
    assign bus.o_rdata  = rdata_p2;
    assign bus.o_err    = err_p1;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed load/store/error/reset scenarios and randomized traffic
// against a cycle-scheduled behavioural model of the controller and its memory.
module tb_data_mem_ctrl;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  ram_waddr;
    logic [8:0]  ram_raddr;
    logic [31:0] ram_din;
    logic [3:0]  ram_wen;
    logic        ram_ren;
    logic [31:0] ram_dout = '0;

    int checks = 0;
    int errors = 0;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_ram_waddr (ram_waddr),
        .o_ram_raddr (ram_raddr),
        .o_ram_din   (ram_din),
        .o_ram_wen   (ram_wen),
        .o_ram_ren   (ram_ren),
        .i_ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE8000 | 32'(i);
    endfunction

    // Byte-enable BRAM with registered read, filled with a known pattern on the first edge.
    logic [31:0] bram [DEPTH];
    logic        bram_init = 1'b0;
    always @(posedge clk) begin
        if (!bram_init) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= init_word(i);
            bram_init <= 1'b1;
        end else begin
            if (ram_ren) ram_dout <= bram[ram_raddr];
            for (int l = 0; l < 4; l++)
                if (ram_wen[l]) bram[ram_waddr][8*l +: 8] <= ram_din[8*l +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic [3:0]  wen;
        logic        ren;
        logic [8:0]  addr;
        logic [31:0] din;
        logic [31:0] rdata;
    } slot_t;

    slot_t       slots [4];
    slot_t       cur;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] held_rdata;
    logic        exp_ready;
    int          cyc = 0;
    int          busy_until = 0;
    logic        pend_v = 1'b0;
    int          pend_cyc;
    int          pend_wi;
    logic [3:0]  pend_wen;
    logic [31:0] pend_din;

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = w >> (8 * off);
        if (size == 2'd0) return (uns || !sh[7]) ? (sh & 32'hFF) : (sh | 32'hFFFFFF00);
        if (size == 2'd1) return (uns || !sh[15]) ? (sh & 32'hFFFF) : (sh | 32'hFFFF0000);
        return w;
    endfunction

    always @(posedge clk) begin
        logic [1:0]  off;
        logic [31:0] wi;
        logic        bad;
        logic [3:0]  w_en;
        logic [31:0] w_din;
        if (cyc == 0)
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        if (rst) begin
            for (int s = 0; s < 4; s++) slots[s] = '0;
            busy_until = cyc + 1;
            held_rdata = '0;
            pend_v     = 1'b0;
        end else begin
            if (pend_v && pend_cyc == cyc) begin
                for (int l = 0; l < 4; l++)
                    if (pend_wen[l]) ref_mem[pend_wi][8*l +: 8] = pend_din[8*l +: 8];
                pend_v = 1'b0;
            end
            if (bus.i_valid && cyc >= busy_until) begin
                off = bus.i_addr[1:0];
                wi  = bus.i_addr >> 2;
                bad = (bus.i_size == 2'd3) || (bus.i_size == 2'd1 && off[0]) ||
                      (bus.i_size == 2'd2 && off != 2'd0) || (wi >= DEPTH);
                if (bad) begin
                    slots[(cyc+1)%4].err = 1'b1;
                end else if (bus.i_we) begin
                    w_en  = (bus.i_size == 2'd0) ? 4'(1 << off) :
                            (bus.i_size == 2'd1) ? 4'(3 << off) : 4'hF;
                    w_din = (bus.i_size == 2'd0) ? {4{bus.i_wdata[7:0]}} :
                            (bus.i_size == 2'd1) ? {2{bus.i_wdata[15:0]}} : bus.i_wdata;
                    slots[(cyc+1)%4].wen  = w_en;
                    slots[(cyc+1)%4].din  = w_din;
                    slots[(cyc+1)%4].addr = wi[8:0];
                    pend_v = 1'b1; pend_cyc = cyc + 1; pend_wi = int'(wi);
                    pend_wen = w_en; pend_din = w_din;
                    busy_until = cyc + 2;
                end else begin
                    slots[(cyc+1)%4].ren   = 1'b1;
                    slots[(cyc+1)%4].addr  = wi[8:0];
                    slots[(cyc+3)%4].rvalid = 1'b1;
                    slots[(cyc+3)%4].rdata = model_load(ref_mem[wi], bus.i_size, off, bus.i_unsigned);
                    busy_until = cyc + 3;
                end
            end
        end
        cyc++;
        cur = slots[cyc%4];
        slots[cyc%4] = '0;
        if (cur.rvalid) held_rdata = cur.rdata;
        exp_ready = (cyc >= busy_until);
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("ready",  32'(bus.o_ready),  32'(exp_ready));
        chk("rvalid", 32'(bus.o_rvalid), 32'(cur.rvalid));
        chk("rdata",  bus.o_rdata,       held_rdata);
        chk("err",    32'(bus.o_err),    32'(cur.err));
        chk("wen",    32'(ram_wen),      rst ? 32'd0 : 32'(cur.wen));
        chk("ren",    32'(ram_ren),      32'(cur.ren));
        chk("waddr",  32'(ram_waddr),    32'(cur.addr));
        chk("raddr",  32'(ram_raddr),    32'(cur.addr));
        chk("din",    ram_din,           cur.din);
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        logic acc;
        acc = 1'b0;
        bus.i_valid = 1'b1; bus.i_we = we; bus.i_size = size;
        bus.i_unsigned = uns; bus.i_addr = addr; bus.i_wdata = wdata;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = bus.o_ready && !rst;
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic store(input string nm, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] ewen, input logic [31:0] edin);
        issue(1'b1, size, 1'b0, addr, wdata);
        @(negedge clk);
        chk({nm, "_wen"}, 32'(ram_wen), 32'(ewen));
        chk({nm, "_din"}, ram_din, edin);
        chk({nm, "_waddr"}, 32'(ram_waddr), addr >> 2);
        @(posedge clk); #1;
    endtask

    task automatic load_chk(input string nm, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] exp);
        int lat;
        lat = -1;
        issue(1'b0, size, uns, addr, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.o_rvalid && lat < 0) begin
                lat = k;
                chk(nm, bus.o_rdata, exp);
            end
            @(posedge clk); #1;
        end
        chk({nm, "_lat"}, 32'(lat), 32'd2);
    endtask

    task automatic err_req(input string nm, input logic we, input logic [1:0] size,
                           input logic [31:0] addr);
        int rv;
        rv = 0;
        issue(we, size, 1'b0, addr, 32'hFFFFFFFF);
        @(negedge clk);
        chk({nm, "_err"},   32'(bus.o_err),   32'd1);
        chk({nm, "_ren"},   32'(ram_ren),     32'd0);
        chk({nm, "_wen"},   32'(ram_wen),     32'd0);
        chk({nm, "_ready"}, 32'(bus.o_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.o_rvalid) rv++;
        end
        chk({nm, "_norv"}, 32'(rv), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n, rv_n;
        bus.i_valid = 1'b0; bus.i_we = 1'b0; bus.i_size = 2'd0;
        bus.i_unsigned = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
        @(negedge clk);
        chk("rst_ready",  32'(bus.o_ready),  32'd1);
        chk("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
        chk("rst_rdata",  bus.o_rdata,       32'd0);
        chk("rst_wen",    32'(ram_wen),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        store("sw", 2'd2, 32'h010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        load_chk("lw10", 2'd2, 1'b0, 32'h010, 32'hDEADBEEF);
        store("sb", 2'd0, 32'h013, 32'h00000180, 4'b1000, 32'h80808080);
        load_chk("lb13",  2'd0, 1'b0, 32'h013, 32'hFFFFFF80);
        load_chk("lbu13", 2'd0, 1'b1, 32'h013, 32'h00000080);
        load_chk("lw10b", 2'd2, 1'b0, 32'h010, 32'h80ADBEEF);
        store("sh", 2'd1, 32'h022, 32'h00008001, 4'b1100, 32'h80018001);
        load_chk("lh22",  2'd1, 1'b0, 32'h022, 32'hFFFF8001);
        load_chk("lhu22", 2'd1, 1'b1, 32'h022, 32'h00008001);
        load_chk("lh20",  2'd1, 1'b0, 32'h020, 32'hFFFF8008);

        err_req("e_lw11",  1'b0, 2'd2, 32'h011);
        err_req("e_lh801", 1'b0, 2'd1, 32'h801);
        err_req("e_lw800", 1'b0, 2'd2, 32'h800);
        err_req("e_sz3",   1'b0, 2'd3, 32'h000);
        err_req("e_sw800", 1'b1, 2'd2, 32'h800);

        // Requester holds a load for nine cycles: three accepts, three results.
        acc_n = 0; rv_n = 0;
        bus.i_valid = 1'b1; bus.i_we = 1'b0; bus.i_size = 2'd2; bus.i_addr = 32'h010;
        for (int k = 0; k < 12; k++) begin
            if (k == 9) bus.i_valid = 1'b0;
            @(negedge clk);
            if (bus.i_valid && bus.o_ready) acc_n++;
            if (bus.o_rvalid) rv_n++;
            @(posedge clk); #1;
        end
        chk("b2b_accepts", 32'(acc_n), 32'd3);
        chk("b2b_rvalids", 32'(rv_n),  32'd3);

        // Reset while the load waits for BRAM data
        rv_n = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h010, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.o_rvalid) rv_n++;
            @(posedge clk); #1;
        end
        chk("rst_wait_norv", 32'(rv_n), 32'd0);

        // Reset while a store is in ACCESS
        issue(1'b1, 2'd2, 1'b0, 32'h010, 32'h11111111);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_acc_wen", 32'(ram_wen), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        load_chk("lw_after_rst", 2'd2, 1'b0, 32'h010, 32'h80ADBEEF);

        // Randomized traffic, including misaligned/out-of-range requests and stray resets
        for (int k = 0; k < 2000; k++) begin
            rst            = ($urandom_range(0, 99) == 0);
            bus.i_valid    = ($urandom_range(0, 2) != 0);
            bus.i_we       = $urandom_range(0, 1) != 0;
            bus.i_size     = 2'($urandom_range(0, 3));
            bus.i_unsigned = $urandom_range(0, 1) != 0;
            case ($urandom_range(0, 9))
                0:       bus.i_addr = $urandom;
                1:       bus.i_addr = 32'h7F8 + 32'($urandom_range(0, 15));
                default: bus.i_addr = 32'($urandom_range(0, 63));
            endcase
            bus.i_wdata = $urandom;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.i_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store front end for the MIPS data memory. It sits directly upstream of the byte-enable simple-dual-port BRAM and drives that BRAM's write/read address, data, byte-enable and read-enable inputs. It accepts one byte/half/word request at a time from the MEM stage, performs lane alignment and misalignment/range checking, and returns sign- or zero-extended load data after the BRAM's one-cycle registered read.

## Interface
- NB_COL, 4, byte lanes per word (fixed 4 for MIPS)
- COL_WIDTH, 8, bits per lane (fixed 8)
- RAM_DEPTH, 512, words in the downstream BRAM; AW = clogb2(RAM_DEPTH-1) (9 at default)
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  request present
- i_we  in  1  1 = store, 0 = load
- i_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- i_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend; ignored for stores
- i_addr  in  32  byte address, little-endian lanes (offset 0 = bits [7:0])
- i_wdata  in  32  store data, right-justified
- o_ready  out  1  high in IDLE; request accepted when i_valid & o_ready
- o_rvalid  out  1  one-cycle pulse, o_rdata valid
- o_rdata  out  32  extended load result, held until next load completes
- o_err  out  1  one-cycle pulse, request rejected
- o_ram_waddr, o_ram_raddr  out  AW  word address (i_addr[AW+1:2])
- o_ram_din  out  32  lane-replicated store data
- o_ram_wen  out  4  byte write enables
- o_ram_ren  out  1  BRAM read enable
- i_ram_dout  in  32  BRAM registered read data

## Operation
- FSM states: IDLE, ACCESS, WAIT. Reset → IDLE.
- IDLE: o_ready=1. On accept, check errors: size==11; half with addr[0]=1; word with addr[1:0]≠0; addr[31:2] ≥ RAM_DEPTH. On error: stay IDLE, o_err=1 next cycle, no BRAM activity, no o_rvalid. Otherwise register request and go to ACCESS.
- ACCESS: registered BRAM outputs driven. Store: o_ram_wen per alignment, o_ram_ren=0, next IDLE. Load: o_ram_ren=1, o_ram_wen=0, next WAIT.
- WAIT: i_ram_dout valid. Select lane(s) with registered addr[1:0]/size, extend, register into o_rdata, assert o_rvalid next cycle, next IDLE.
- Store alignment: byte, din = {4{wdata[7:0]}}, wen = 1<<addr[1:0]. Half, din = {2{wdata[15:0]}}, wen = addr[1] ? 1100 : 0011. Word, din = wdata, wen = 1111.
- Load extraction: byte, lane addr[1:0]. Half, bits [31:16] if addr[1] else [15:0]. Extend bit 7 or 15 unless i_unsigned.
- o_ram_waddr and o_ram_raddr both carry the registered word address. Both are 0 outside ACCESS. o_ram_din is 0 outside ACCESS.

## Timing
- C0 = accept cycle. Store: C1 ACCESS, memory updated at end of C1, o_ready=1 in C2. Max throughput 1 store per 2 cycles.
- Load: C1 ACCESS (ren=1), C2 WAIT, C3 o_rvalid=1 with o_ready=1. A new request may be accepted in C3. Max throughput 1 load per 3 cycles.
- Error: o_err=1 in C1 and o_ready stays 1, so a new request can be accepted in C1.
- Requests with i_valid high while o_ready=0 are ignored, not queued. The requester holds them.
- Reset values: state IDLE, o_ready=1, o_rvalid=0, o_err=0, o_rdata=0, o_ram_wen=0, o_ram_ren=0, addresses/din=0.
- While i_rst=1, requests are ignored and o_ram_wen is forced 0 combinationally. A store in ACCESS during reset does not write.
- Reset in ACCESS (load) or WAIT abandons the load: no o_rvalid, IDLE next cycle.

## Test plan
- SW 0xDEADBEEF @0x010, then LW @0x010 → wen=1111, waddr=4; o_rvalid in C3 with o_rdata=0xDEADBEEF.
- SB wdata=0x180 @0x013 → wen=1000, din=0x80808080. Then LB @0x013 → 0xFFFFFF80, LBU → 0x00000080, LW @0x010 → 0x80ADBEEF.
- SH 0x8001 @0x022 → wen=1100. Then LH @0x022 → 0xFFFF8001, LHU → 0x00008001, LH @0x020 → previous low half.
- Errors: LW @0x011, LH @0x801, LW @0x800, size=11 @0x000 → each gives o_err pulse in C1, ren=wen=0, no o_rvalid, o_ready stays 1.
- Back-to-back: i_valid held with 3 loads → accepts at cycles 0, 3, 6; o_rvalid at 3, 6, 9; no extra accepts.
- Reset mid-op: i_rst in WAIT → no o_rvalid. i_rst during store ACCESS → wen=0 and a later LW returns old data.
